// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : RISC-V style ALU execution unit. It decodes alu_op/fun3/fun7 into
//            a 4-bit control code and performs the operation. The result is
//            held in a register behind a valid/ready handshake.
//            Shifts are iterative, one bit per cycle, unless
//            ALU_BARREL_SHIFT_EN is defined. With that macro every operation
//            completes in a single cycle.
// Ports    : clk          - clock, rising edge
//            rst_n        - asynchronous active-low reset
//            i_alu_op     - op class (00 ADD, 01 SUB, 10 R-type, 11 I-type)
//            i_fun7       - instruction bit 30
//            i_fun3       - instruction bits 14:12
//            i_op_a/i_op_b- operands (XLEN bits)
//            i_in_valid   - request valid;  o_in_ready - request ready
//            o_result     - registered result
//            o_zero       - result == 0
//            o_ctrl       - decoded operation of the held result
//            o_out_valid  - response valid; i_out_ready - response ready
// Macro    : ALU_BARREL_SHIFT_EN (optional single-cycle shifter)
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      i_alu_op,
  input  logic            i_fun7,
  input  logic [2:0]      i_fun3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic [3:0]      o_ctrl,
  output logic            o_out_valid,
  input  logic            i_out_ready
);

  localparam logic [3:0] c_CTRL_AND  = 4'b0000;
  localparam logic [3:0] c_CTRL_OR   = 4'b0001;
  localparam logic [3:0] c_CTRL_ADD  = 4'b0010;
  localparam logic [3:0] c_CTRL_XOR  = 4'b0011;
  localparam logic [3:0] c_CTRL_SLL  = 4'b0100;
  localparam logic [3:0] c_CTRL_SRL  = 4'b0101;
  localparam logic [3:0] c_CTRL_SUB  = 4'b0110;
  localparam logic [3:0] c_CTRL_SRA  = 4'b0111;
  localparam logic [3:0] c_CTRL_SLT  = 4'b1000;
  localparam logic [3:0] c_CTRL_SLTU = 4'b1001;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SHIFT = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            r_rst_done;
  logic [XLEN-1:0] r_result;
  logic [3:0]      r_ctrl;
  logic [SHW-1:0]  r_cnt;

  logic [3:0]      w_ctrl;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu_res;
  logic [XLEN-1:0] w_step;
  logic            w_slt;
  logic            w_sltu;
  logic            w_accept;
  logic            w_shift_seq;

  assign w_shamt  = i_op_b[SHW-1:0];
  assign w_slt    = $signed(i_op_a) < $signed(i_op_b);
  assign w_sltu   = i_op_a < i_op_b;
  assign w_accept = i_in_valid && o_in_ready;

  // --------------------------------------------------------------------------
  // Decode. Any combination that is not listed falls back to ADD.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ctrl = c_CTRL_ADD;
    case (i_alu_op)
      2'b00: w_ctrl = c_CTRL_ADD;
      2'b01: w_ctrl = c_CTRL_SUB;
      default: begin
        case (i_fun3)
          3'b000: w_ctrl = (i_alu_op == 2'b10 && i_fun7) ? c_CTRL_SUB : c_CTRL_ADD;
          3'b001: w_ctrl = c_CTRL_SLL;
          3'b010: w_ctrl = c_CTRL_SLT;
          3'b011: w_ctrl = c_CTRL_SLTU;
          3'b100: w_ctrl = c_CTRL_XOR;
          3'b101: w_ctrl = i_fun7 ? c_CTRL_SRA : c_CTRL_SRL;
          3'b110: w_ctrl = c_CTRL_OR;
          3'b111: w_ctrl = c_CTRL_AND;
          default: w_ctrl = c_CTRL_ADD;
        endcase
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Single-cycle datapath. In the iterative build the shift ops return op_a
  // here. This value is the final result when the shift amount is zero. For a
  // non-zero amount it is the starting value that the SHIFT state walks.
  // --------------------------------------------------------------------------
  always_comb begin
    w_alu_res = i_op_a + i_op_b;
    case (w_ctrl)
      c_CTRL_ADD:  w_alu_res = i_op_a + i_op_b;
      c_CTRL_SUB:  w_alu_res = i_op_a - i_op_b;
      c_CTRL_AND:  w_alu_res = i_op_a & i_op_b;
      c_CTRL_OR:   w_alu_res = i_op_a | i_op_b;
      c_CTRL_XOR:  w_alu_res = i_op_a ^ i_op_b;
      c_CTRL_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, w_slt};
      c_CTRL_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_sltu};
`ifdef ALU_BARREL_SHIFT_EN
      c_CTRL_SLL:  w_alu_res = i_op_a << w_shamt;
      c_CTRL_SRL:  w_alu_res = i_op_a >> w_shamt;
      c_CTRL_SRA:  w_alu_res = $unsigned($signed(i_op_a) >>> w_shamt);
`else
      c_CTRL_SLL:  w_alu_res = i_op_a;
      c_CTRL_SRL:  w_alu_res = i_op_a;
      c_CTRL_SRA:  w_alu_res = i_op_a;
`endif
      default:     w_alu_res = i_op_a + i_op_b;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign w_shift_seq = 1'b0;
`else
  assign w_shift_seq = ((w_ctrl == c_CTRL_SLL) || (w_ctrl == c_CTRL_SRL) ||
                        (w_ctrl == c_CTRL_SRA)) && (w_shamt != '0);
`endif

  // One-bit shift step applied to the held result while in SHIFT.
  always_comb begin
    w_step = r_result;
    case (r_ctrl)
      c_CTRL_SLL: w_step = r_result << 1;
      c_CTRL_SRL: w_step = r_result >> 1;
      c_CTRL_SRA: w_step = {r_result[XLEN-1], r_result[XLEN-1:1]};
      default:    w_step = r_result;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_shift_seq ? c_ST_SHIFT : c_ST_DONE;
        end
      end
      c_ST_SHIFT: begin
        // The last step is the one taken while the counter reads 1.
        if (r_cnt == SHW'(1)) begin
          w_state_nxt = c_ST_DONE;
        end
      end
      c_ST_DONE: begin
        if (i_out_ready) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM: outputs. in_ready stays low until the first clock after reset release.
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      c_ST_IDLE: o_in_ready  = r_rst_done;
      c_ST_DONE: o_out_valid = 1'b1;
      default: begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_ctrl   <= c_CTRL_ADD;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_ctrl   <= w_ctrl;
            r_result <= w_alu_res;
            if (w_shift_seq) begin
              r_cnt <= w_shamt;
            end
          end
        end
        c_ST_SHIFT: begin
          r_result <= w_step;
          r_cnt    <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_ctrl   = r_ctrl;
  assign o_zero   = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Directed-vector self-checking bench for alu_exec_unit (XLEN=32
//            and XLEN=8 instances sharing clock and reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [1:0]  r_alu_op = '0;
  logic        r_fun7 = 1'b0;
  logic [2:0]  r_fun3 = '0;
  logic [31:0] r_op_a = '0;
  logic [31:0] r_op_b = '0;
  logic        r_in_valid = 1'b0;
  logic        r_out_ready = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_result;
  logic        w_zero;
  logic [3:0]  w_ctrl;
  logic        w_out_valid;

  logic [1:0]  r8_alu_op = '0;
  logic        r8_fun7 = 1'b0;
  logic [2:0]  r8_fun3 = '0;
  logic [7:0]  r8_op_a = '0;
  logic [7:0]  r8_op_b = '0;
  logic        r8_in_valid = 1'b0;
  logic        r8_out_ready = 1'b0;
  logic        w8_in_ready;
  logic [7:0]  w8_result;
  logic        w8_zero;
  logic [3:0]  w8_ctrl;
  logic        w8_out_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_alu_op    (r_alu_op),
    .i_fun7      (r_fun7),
    .i_fun3      (r_fun3),
    .i_op_a      (r_op_a),
    .i_op_b      (r_op_b),
    .i_in_valid  (r_in_valid),
    .o_in_ready  (w_in_ready),
    .o_result    (w_result),
    .o_zero      (w_zero),
    .o_ctrl      (w_ctrl),
    .o_out_valid (w_out_valid),
    .i_out_ready (r_out_ready)
  );

  alu_exec_unit #(.XLEN(8)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_alu_op    (r8_alu_op),
    .i_fun7      (r8_fun7),
    .i_fun3      (r8_fun3),
    .i_op_a      (r8_op_a),
    .i_op_b      (r8_op_b),
    .i_in_valid  (r8_in_valid),
    .o_in_ready  (w8_in_ready),
    .o_result    (w8_result),
    .o_zero      (w8_zero),
    .o_ctrl      (w8_ctrl),
    .o_out_valid (w8_out_valid),
    .i_out_ready (r8_out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until the edge where it is accepted.
  task automatic send(input logic [1:0] op, input logic f7, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    while (!w_in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("in_ready_wait", {63'd0, w_in_ready}, 64'd1);
    r_alu_op = op; r_fun7 = f7; r_fun3 = f3; r_op_a = a; r_op_b = b;
    r_in_valid = 1'b1;
    tick();
    r_in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid (1 = visible right after it).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!w_out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic retire();
    check("bubble_in_ready", {63'd0, w_in_ready}, 64'd0);
    r_out_ready = 1'b1;
    tick();
    r_out_ready = 1'b0;
    check("retire_out_valid", {63'd0, w_out_valid}, 64'd0);
    check("retire_in_ready", {63'd0, w_in_ready}, 64'd1);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic f7,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic [3:0] ctl, input int lat_iter);
    int lat;
    int exp_lat;
`ifdef ALU_BARREL_SHIFT_EN
    exp_lat = 1;
`else
    exp_lat = lat_iter;
`endif
    send(op, f7, f3, a, b);
    wait_valid(lat);
    check({tag, "_lat"},    64'(lat), 64'(exp_lat));
    check({tag, "_result"}, {32'd0, w_result}, {32'd0, res});
    check({tag, "_ctrl"},   {60'd0, w_ctrl}, {60'd0, ctl});
    check({tag, "_zero"},   {63'd0, w_zero}, {63'd0, (res == 32'd0)});
    retire();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready",  {63'd0, w_in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, w_out_valid}, 64'd0);
    check("rst_result",    {32'd0, w_result}, 64'd0);
    check("rst_ctrl",      {60'd0, w_ctrl}, 64'h2);
    check("rst_zero",      {63'd0, w_zero}, 64'd1);
    tick();
    tick();
    check("rst_hold_in_ready", {63'd0, w_in_ready}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", {63'd0, w_in_ready}, 64'd1);

    //   tag       op     f7    f3      a             b             result        ctrl   lat(iterative)
    run("sub_r",   2'b10, 1'b1, 3'b000, 32'd5,        32'd7,        32'hFFFFFFFE, 4'h6, 1);
    run("sra4",    2'b10, 1'b1, 3'b101, 32'h80000000, 32'd4,        32'hF8000000, 4'h7, 5);
    run("sltu_i",  2'b11, 1'b0, 3'b011, 32'hFFFFFFFF, 32'd1,        32'h0,        4'h9, 1);
    run("slt_i",   2'b11, 1'b0, 3'b010, 32'hFFFFFFFF, 32'd1,        32'h1,        4'h8, 1);
    run("add_00",  2'b00, 1'b1, 3'b111, 32'd3,        32'd4,        32'd7,        4'h2, 1);
    run("sub_01",  2'b01, 1'b0, 3'b100, 32'd3,        32'd4,        32'hFFFFFFFF, 4'h6, 1);
    run("addi_f7", 2'b11, 1'b1, 3'b000, 32'd10,       32'd3,        32'd13,       4'h2, 1);
    run("sll3",    2'b10, 1'b0, 3'b001, 32'd1,        32'h23,       32'd8,        4'h4, 4);
    run("srl4",    2'b10, 1'b0, 3'b101, 32'h80000000, 32'd4,        32'h08000000, 4'h5, 5);
    run("sll0",    2'b10, 1'b0, 3'b001, 32'h1234,     32'h20,       32'h1234,     4'h4, 1);
    run("sra31",   2'b11, 1'b1, 3'b101, 32'h80000000, 32'd31,       32'hFFFFFFFF, 4'h7, 32);
    run("and_r",   2'b10, 1'b0, 3'b111, 32'hF0F0,     32'hFF00,     32'hF000,     4'h0, 1);
    run("or_r",    2'b10, 1'b0, 3'b110, 32'hF0F0,     32'hFF00,     32'hFFF0,     4'h1, 1);
    run("xor_r",   2'b10, 1'b0, 3'b100, 32'hF0F0,     32'hFF00,     32'h0FF0,     4'h3, 1);
    run("add_wrap",2'b10, 1'b0, 3'b000, 32'hFFFFFFFF, 32'd2,        32'd1,        4'h2, 1);

    // Hold the response with out_ready low while a second request is offered.
    begin
      int lat;
      send(2'b10, 1'b0, 3'b000, 32'd1, 32'd1);
      wait_valid(lat);
      check("hold_lat", 64'(lat), 64'd1);
      r_alu_op = 2'b10; r_fun7 = 1'b0; r_fun3 = 3'b110; r_op_a = 32'd100; r_op_b = 32'd3;
      r_in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        check("hold_result",    {32'd0, w_result}, 64'd2);
        check("hold_out_valid", {63'd0, w_out_valid}, 64'd1);
        check("hold_in_ready",  {63'd0, w_in_ready}, 64'd0);
        check("hold_ctrl",      {60'd0, w_ctrl}, 64'h2);
      end
      r_in_valid = 1'b0;
      retire();
      check("hold_no_capture", {32'd0, w_result}, 64'd2);
    end

    // Reset in the middle of a long shift.
    send(2'b10, 1'b1, 3'b101, 32'h80000000, 32'd20);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {63'd0, w_out_valid}, 64'd0);
    check("abort_in_ready",  {63'd0, w_in_ready}, 64'd0);
    check("abort_result",    {32'd0, w_result}, 64'd0);
    check("abort_zero",      {63'd0, w_zero}, 64'd1);
    check("abort_ctrl",      {60'd0, w_ctrl}, 64'h2);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_rel_in_ready", {63'd0, w_in_ready}, 64'd1);
    check("abort_rel_out_valid", {63'd0, w_out_valid}, 64'd0);
    run("after_abort", 2'b00, 1'b0, 3'b000, 32'd20, 32'd22, 32'd42, 4'h2, 1);

    // XLEN=8 wrap-around to zero.
    check("x8_in_ready", {63'd0, w8_in_ready}, 64'd1);
    r8_alu_op = 2'b00; r8_op_a = 8'hFF; r8_op_b = 8'h01; r8_in_valid = 1'b1;
    tick();
    r8_in_valid = 1'b0;
    check("x8_out_valid", {63'd0, w8_out_valid}, 64'd1);
    check("x8_result",    {56'd0, w8_result}, 64'd0);
    check("x8_zero",      {63'd0, w8_zero}, 64'd1);
    check("x8_ctrl",      {60'd0, w8_ctrl}, 64'h2);
    r8_out_ready = 1'b1;
    tick();
    r8_out_ready = 1'b0;
    check("x8_retire", {63'd0, w8_out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
